spram_ctrl: RTL and testbench

SPRAM_CTRL -- requirements
Module: spram_ctrl

---
 rtl/spram_ctrl_pkg.sv | 7 +
 rtl/spram_tmo_cnt.sv | 19 +
 rtl/spram_ctrl.sv | 81 ++++++++
 tb/tb_spram_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spram_ctrl_pkg.sv
// spram_ctrl_pkg: shared state encoding, bus widths and default timeout for the RAM controller
package spram_ctrl_pkg;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
endpackage

// File: rtl/spram_tmo_cnt.sv
// spram_tmo_cnt: saturating count of strobe cycles, flags the last cycle of the timeout budget
module spram_tmo_cnt
  import spram_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt_q;
  always_ff @(posedge clk)
    if (rst || clr) cnt_q <= '0;
    else if (en && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
  // cnt_q holds completed strobe cycles, so the current one is number TIMEOUT at TIMEOUT-1
  assign expired = cnt_q >= 8'(TIMEOUT - 1);
endmodule

// File: rtl/spram_ctrl.sv
// spram_ctrl: request/response front end driving a 256x16 single-port RAM with a READY timeout
module spram_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic          REQ_WE,
  input  logic [AW-1:0] REQ_AD,
  input  logic [DW-1:0] REQ_DI,
  output logic          RSP_VALID,
  output logic [DW-1:0] RSP_DO,
  output logic          RSP_ERR,
  output logic          RAM_CS,
  output logic          RAM_EN,
  output logic          RAM_RD,
  output logic          RAM_WR,
  output logic [AW-1:0] RAM_AD,
  output logic [DW-1:0] RAM_DI,
  input  logic          RAM_READY,
  input  logic [DW-1:0] RAM_DO
);
  state_t state_q, state_d;
  logic ready_q, we_q, err_q, expired, accept, finish;
  logic [AW-1:0] ad_q;
  logic [DW-1:0] di_q, do_q;
  assign accept = REQ_VALID && ready_q;
  assign finish = state_q == STROBE && (RAM_READY || expired);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SETUP : IDLE;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = finish ? DONE : STROBE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      ad_q    <= '0;
      di_q    <= '0;
      do_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d == IDLE;
      if (accept) begin
        we_q <= REQ_WE;
        ad_q <= REQ_AD;
        di_q <= REQ_DI;
      end
      // READY wins over an expiring budget in the same cycle
      if (finish) begin
        do_q  <= (RAM_READY && !we_q) ? RAM_DO : '0;
        err_q <= !RAM_READY;
      end
    end
  spram_tmo_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(CLK),
    .rst(RST),
    .clr(accept),
    .en(state_q == STROBE),
    .expired(expired)
  );
  assign REQ_READY = ready_q;
  assign RAM_CS    = state_q == SETUP || state_q == STROBE;
  assign RAM_EN    = RAM_CS;
  assign RAM_RD    = state_q == STROBE && !we_q;
  assign RAM_WR    = state_q == STROBE && we_q;
  assign RAM_AD    = ad_q;
  assign RAM_DI    = di_q;
  assign RSP_VALID = state_q == DONE;
  assign RSP_DO    = do_q;
  assign RSP_ERR   = err_q;
endmodule

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl: directed transactions against a RAM model, with a timeline model checked every cycle
module tb_spram_ctrl;
  localparam int TMO = 15;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0, ram_ready = 1'b0;
  logic [7:0] req_ad = '0;
  logic [15:0] req_di = '0, ram_do = '0;
  logic req_ready, rsp_valid, rsp_err, ram_cs, ram_en, ram_rd, ram_wr;
  logic [15:0] rsp_do, ram_di;
  logic [7:0] ram_ad;
  int checks = 0, errors = 0, cyc_n = 0;
  int ready_at = 1, rk = 0;
  bit rdy_setup = 1'b0;
  logic [15:0] mem_r [256];
  logic [15:0] mem_m [256];

  spram_ctrl #(.TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_AD(req_ad), .REQ_DI(req_di), .RSP_VALID(rsp_valid), .RSP_DO(rsp_do), .RSP_ERR(rsp_err),
    .RAM_CS(ram_cs), .RAM_EN(ram_en), .RAM_RD(ram_rd), .RAM_WR(ram_wr), .RAM_AD(ram_ad),
    .RAM_DI(ram_di), .RAM_READY(ram_ready), .RAM_DO(ram_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM: READY on strobe cycle ready_at (0 = never), optionally also during SETUP
  always @(negedge clk) begin
    if (ram_rd || ram_wr) rk++; else rk = 0;
    ram_ready = ((ram_rd || ram_wr) && rk == ready_at) || (rdy_setup && ram_cs && !ram_rd && !ram_wr);
    ram_do = mem_r[ram_ad];
    if (ram_wr && ram_ready) mem_r[ram_ad] = ram_di;
  end

  // Timeline model: after acceptance, cycle 1 is setup, then S strobe cycles, then the response
  bit busy = 1'b0, rm = 1'b0, mwe = 1'b0, m_err = 1'b0, p_err = 1'b0, p_ok = 1'b0;
  int mc = 0, ms = 0;
  logic [7:0] m_ad = '0;
  logic [15:0] m_di = '0, m_do = '0, p_do = '0;
  logic e_cs, e_st;
  logic [46:0] got_v, exp_v;
  always @(negedge clk) begin
    e_cs = busy && mc >= 1 && mc <= 1 + ms;
    e_st = busy && mc >= 2 && mc <= 1 + ms;
    got_v = {req_ready, ram_cs, ram_en, ram_rd, ram_wr, rsp_valid, rsp_err, rsp_do, ram_ad, ram_di};
    exp_v = {rm, e_cs, e_cs, e_st && !mwe, e_st && mwe, busy && mc == 2 + ms, m_err, m_do, m_ad, m_di};
    chk($sformatf("cycle%0d outputs", cyc_n), 64'(got_v), 64'(exp_v));
    if (rst) begin
      busy = 0; rm = 0; mwe = 0; m_ad = '0; m_di = '0; m_do = '0; m_err = 0;
    end else if (busy) begin
      if (mc == 1 + ms) begin
        m_do = p_do;
        m_err = p_err;
        if (p_ok && mwe) mem_m[m_ad] = m_di;
      end
      if (mc == 2 + ms) begin busy = 0; rm = 1; end
      else mc++;
    end else if (rm && req_valid) begin
      busy = 1; mc = 1; rm = 0;
      mwe = req_we; m_ad = req_ad; m_di = req_di;
      p_ok = ready_at >= 1 && ready_at <= TMO;
      ms = p_ok ? ready_at : TMO;
      p_err = !p_ok;
      p_do = (p_ok && !req_we) ? mem_m[req_ad] : '0;
    end else rm = 1;
  end

  task automatic req(input bit we, input logic [7:0] ad, input logic [15:0] di, input int rat);
    int n = 0;
    @(posedge clk); #2;
    ready_at = rat;
    while (!req_ready && n < 60) begin @(posedge clk); #2; n++; end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1; req_we = we; req_ad = ad; req_di = di;
    @(posedge clk); #2;
    req_valid = 0; req_we = ~we; req_ad = ~ad; req_di = ~di;
  endtask

  task automatic wait_rsp(output int lat, output int nrd, output int nwr);
    lat = 0; nrd = 0; nwr = 0;
    do begin
      @(negedge clk);
      lat++; nrd += int'(ram_rd); nwr += int'(ram_wr);
    end while (!rsp_valid && lat < 300);
    chk("rsp_seen", 64'(rsp_valid), 64'd1);
  endtask

  int lat, nrd, nwr, k2, t0, nv;
  int acc_t[$];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_r[i] = {8'(i), ~8'(i)};
      mem_m[i] = {8'(i), ~8'(i)};
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({req_ready, ram_cs, ram_rd, ram_wr, rsp_valid, rsp_err, rsp_do, ram_ad, ram_di}), 64'd0);
    @(posedge clk); #2; rst = 0;
    @(negedge clk); chk("ready_low_before_edge", 64'(req_ready), 64'd0);
    @(negedge clk); chk("ready_rises", 64'(req_ready), 64'd1);
    // write with immediate READY
    req(1'b1, 8'h3c, 16'ha55a, 1);
    wait_rsp(lat, nrd, nwr);
    chk("wr_latency", 64'(lat), 64'd3);
    chk("wr_strobes", 64'(nwr), 64'd1);
    chk("wr_rsp", 64'({rsp_err, rsp_do}), 64'd0);
    // read back with READY on the 4th strobe cycle
    req(1'b0, 8'h3c, 16'h0000, 4);
    wait_rsp(lat, nrd, nwr);
    chk("rd_strobes", 64'(nrd), 64'd4);
    chk("rd_rsp", 64'({rsp_err, rsp_do}), 64'h0a55a);
    chk("rd_latency", 64'(lat), 64'd6);
    // READY never arrives
    req(1'b0, 8'h05, 16'h0000, 0);
    wait_rsp(lat, nrd, nwr);
    chk("tmo_strobes", 64'(nrd), 64'd15);
    chk("tmo_rsp", 64'({rsp_err, rsp_do}), 64'h10000);
    @(negedge clk); chk("tmo_ready_back", 64'(req_ready), 64'd1);
    // READY on the final allowed strobe cycle
    req(1'b0, 8'h3c, 16'h0000, 15);
    wait_rsp(lat, nrd, nwr);
    chk("edge_strobes", 64'(nrd), 64'd15);
    chk("edge_rsp", 64'({rsp_err, rsp_do}), 64'h0a55a);
    // READY during SETUP must be ignored
    rdy_setup = 1;
    req(1'b0, 8'h07, 16'h0000, 2);
    wait_rsp(lat, nrd, nwr);
    chk("setup_ready_latency", 64'(lat), 64'd4);
    chk("setup_ready_rsp", 64'({rsp_err, rsp_do}), 64'h007f8);
    @(posedge clk); #2; rdy_setup = 0;
    // reset during a write strobe
    req(1'b1, 8'h40, 16'h1234, 10);
    @(negedge clk); @(negedge clk);
    chk("abort_in_strobe", 64'(ram_wr), 64'd1);
    @(posedge clk); #2; rst = 1;
    @(posedge clk); #2; rst = 0;
    @(negedge clk);
    chk("abort_outputs", 64'({ram_cs, ram_en, ram_wr, rsp_valid, req_ready}), 64'd0);
    nv = 0;
    repeat (8) begin @(negedge clk); nv += int'(rsp_valid); end
    chk("abort_no_rsp", 64'(nv), 64'd0);
    req(1'b0, 8'h40, 16'h0000, 2);
    wait_rsp(lat, nrd, nwr);
    chk("after_abort_rsp", 64'({rsp_err, rsp_do}), 64'h040bf);
    // three back-to-back writes with REQ_VALID held and inputs churning mid-transaction
    @(posedge clk); #2;
    ready_at = 1;
    req_valid = 1; req_we = 1; req_ad = 8'h10; req_di = 16'h1111;
    t0 = cyc_n;
    while (acc_t.size() < 3 && cyc_n - t0 < 60) begin
      @(negedge clk);
      if (req_ready) begin
        acc_t.push_back(cyc_n);
        k2 = acc_t.size();
        @(posedge clk); #2; req_we = 0; req_ad = 8'hee; req_di = 16'hdead;
        @(posedge clk); #2; req_ad = 8'h77; req_di = 16'hbeef;
        @(posedge clk); #2;
        if (k2 < 3) begin req_we = 1; req_ad = 8'h10 + 8'(k2); req_di = 16'h1111 * 16'(k2 + 1); end
        else req_valid = 0;
      end else begin
        @(posedge clk); #2;
      end
    end
    req_valid = 0;
    chk("b2b_accepts", 64'(acc_t.size()), 64'd3);
    if (acc_t.size() == 3) begin
      chk("b2b_gap1", 64'(acc_t[1] - acc_t[0]), 64'd4);
      chk("b2b_gap2", 64'(acc_t[2] - acc_t[1]), 64'd4);
    end
    req(1'b0, 8'h11, 16'h0000, 1);
    wait_rsp(lat, nrd, nwr);
    chk("b2b_read11", 64'({rsp_err, rsp_do}), 64'h02222);
    req(1'b0, 8'h12, 16'h0000, 3);
    wait_rsp(lat, nrd, nwr);
    chk("b2b_read12", 64'({rsp_err, rsp_do}), 64'h03333);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
